// File: rtl/inst_mem_pkg.sv
// Shared types for the streaming instruction memory: loader FSM states and default NOP word.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/inst_mem_stream_if.sv
// Bundle of loader stream, status and fetch signals for inst_mem_stream.
interface inst_mem_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_count;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              load_busy;
  logic              load_done;
  logic [31:0]       fetch_addr;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              fetch_fault;

  modport master (
    output load_start, load_base, load_count, ld_valid, ld_data, fetch_addr,
    input  ld_ready, load_busy, load_done, inst, inst_valid, fetch_fault
  );

  modport slave (
    input  load_start, load_base, load_count, ld_valid, ld_data, fetch_addr,
    output ld_ready, load_busy, load_done, inst, inst_valid, fetch_fault
  );
endinterface

// File: rtl/inst_mem_load_ctrl.sv
// Loader FSM for inst_mem_stream: tracks write pointer and remaining word count,
// produces ld_ready/load_busy/load_done and the array write strobe.
module inst_mem_load_ctrl
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W:0]   count_clamped;

  assign count_clamped = (load_count > DEPTH_C) ? DEPTH_C : load_count;
  assign wr_addr       = ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    ld_ready  = 1'b0;
    load_busy = 1'b1;
    load_done = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        load_busy = 1'b0;
        if (load_start) begin
          ptr_d   = load_base;
          rem_d   = count_clamped;
          state_d = (count_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          // pointer is ADDR_W wide, so DEPTH-1 -> 0 wraps naturally
          wr_en = 1'b1;
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = DONE;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/inst_mem_stream.sv
// Instruction memory with combinational fetch and valid/ready stream loader.
// Define INSTMEM_FETCH_CHECK_EN to enable misaligned/out-of-range fetch faulting.
module inst_mem_stream
  import inst_mem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input logic              clk,
  input logic              rst_n,
  inst_mem_stream_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] idx;
  logic              fault;

  inst_mem_load_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (bus.load_start),
    .load_base  (bus.load_base),
    .load_count (bus.load_count),
    .ld_valid   (bus.ld_valid),
    .ld_ready   (bus.ld_ready),
    .load_busy  (bus.load_busy),
    .load_done  (bus.load_done),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  // Array is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.ld_data;
  end

  assign idx = bus.fetch_addr[ADDR_W+1:2];

`ifdef INSTMEM_FETCH_CHECK_EN
  assign fault = (bus.fetch_addr[1:0] != 2'b00) ||
                 (bus.fetch_addr >= 32'(4 * DEPTH));
`else
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0]};
  assign fault             = 1'b0;
`endif

  assign bus.fetch_fault = fault;

  always_comb begin
    bus.inst       = NOP_WORD;
    bus.inst_valid = 1'b0;
    if (!bus.load_busy && !fault) begin
      bus.inst       = mem_q[idx];
      bus.inst_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_mem_stream.sv
// Directed self-checking bench for inst_mem_stream (DEPTH=64, DATA_W=32).
module tb_inst_mem_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errs    = 0;
  logic [31:0] wq [$];

  always #5 clk = ~clk;

  inst_mem_stream_if #(.DATA_W(32), .DEPTH(64)) bus ();

  inst_mem_stream #(.DATA_W(32), .DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.fetch_addr = addr;
    #1;
    chk(tag, bus.inst, exp);
    chk({tag, "_v"}, bus.inst_valid, 1'b1);
  endtask

  // Streams wq back-to-back; expects done pulse right after the last handshake.
  task automatic do_load(input logic [5:0] base, input logic [6:0] cnt, input int n, input string tag);
    bus.load_base  = base;
    bus.load_count = cnt;
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    chk({tag, "_busy"}, bus.load_busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = wq[i];
      #1;
      chk({tag, "_ready"}, bus.ld_ready, 1'b1);
      chk({tag, "_done_early"}, bus.load_done, 1'b0);
      cyc();
    end
    bus.ld_valid = 1'b0;
    chk({tag, "_done"}, bus.load_done, 1'b1);
    chk({tag, "_ready_done"}, bus.ld_ready, 1'b0);
    chk({tag, "_busy_done"}, bus.load_busy, 1'b1);
    cyc();
    chk({tag, "_done_clr"}, bus.load_done, 1'b0);
    chk({tag, "_idle"}, bus.load_busy, 1'b0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_count = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.fetch_addr = '0;
    #12;
    chk("rst_ready", bus.ld_ready, 1'b0);
    chk("rst_busy", bus.load_busy, 1'b0);
    chk("rst_done", bus.load_done, 1'b0);
    chk("rst_fault", bus.fetch_fault, 1'b0);
    rst_n = 1'b1;
    cyc();

    // 1: base 0, four words
    wq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    bus.fetch_addr = 32'h0;
    bus.load_base = 6'd0; bus.load_count = 7'd4; bus.load_start = 1'b1;
    #1;
    chk("t1_idle_inst_valid", bus.inst_valid, 1'b1);
    do_load(6'd0, 7'd4, 4, "t1");
    fetch(32'h0, 32'hA0, "t1_f0");
    fetch(32'h4, 32'hA1, "t1_f4");
    fetch(32'h8, 32'hA2, "t1_f8");
    fetch(32'hC, 32'hA3, "t1_fC");

    // 2: wrap from 62
    wq = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    do_load(6'd62, 7'd4, 4, "t2");
    fetch(32'hF8, 32'hB0, "t2_f62");
    fetch(32'hFC, 32'hB1, "t2_f63");
    fetch(32'h00, 32'hB2, "t2_f0");
    fetch(32'h04, 32'hB3, "t2_f1");
    fetch(32'h08, 32'hA2, "t2_f2_kept");

    // 3: gapped valid 1,0,0,1,1 into 10..12
    bus.fetch_addr = 32'h28;
    bus.load_base = 6'd10; bus.load_count = 7'd3; bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ld_valid = (i == 0 || i >= 3);
      bus.ld_data  = 32'hC0 + 32'(i);
      #1;
      chk("t3_ready", bus.ld_ready, 1'b1);
      chk("t3_inst_nop", bus.inst, 32'h0);
      chk("t3_inst_valid", bus.inst_valid, 1'b0);
      cyc();
    end
    bus.ld_valid = 1'b0;
    chk("t3_done", bus.load_done, 1'b1);
    chk("t3_inst_nop_done", bus.inst, 32'h0);
    // load_start during DONE must be dropped
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    chk("t3_done_clr", bus.load_done, 1'b0);
    cyc();
    chk("t3_start_ignored", bus.load_busy, 1'b0);
    fetch(32'h28, 32'hC0, "t3_f10");
    fetch(32'h2C, 32'hC3, "t3_f11");
    fetch(32'h30, 32'hC4, "t3_f12");

    // 4: zero-length load
    do_load(6'd10, 7'd0, 0, "t4");
    fetch(32'h28, 32'hC0, "t4_f10_kept");

    // 5: preload 20..24, then reset mid-load after two words
    wq = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
    do_load(6'd20, 7'd5, 5, "t5pre");
    bus.load_base = 6'd20; bus.load_count = 7'd5; bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'hD0;
    cyc();
    bus.ld_data = 32'hD1;
    cyc();
    bus.ld_data = 32'hD2;
    chk("t5_busy_pre", bus.load_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy_async", bus.load_busy, 1'b0);
    chk("t5_ready_async", bus.ld_ready, 1'b0);
    cyc();
    chk("t5_no_done", bus.load_done, 1'b0);
    bus.ld_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("t5_no_done2", bus.load_done, 1'b0);
    fetch(32'h50, 32'hD0, "t5_f20");
    fetch(32'h54, 32'hD1, "t5_f21");
    fetch(32'h58, 32'hE2, "t5_f22");
    fetch(32'h5C, 32'hE3, "t5_f23");
    fetch(32'h60, 32'hE4, "t5_f24");

    // 6: fetch checking / aliasing
`ifdef INSTMEM_FETCH_CHECK_EN
    bus.fetch_addr = 32'h2; #1;
    chk("t6_fault_misal", bus.fetch_fault, 1'b1);
    chk("t6_misal_valid", bus.inst_valid, 1'b0);
    chk("t6_misal_inst", bus.inst, 32'h0);
    bus.fetch_addr = 32'h100; #1;
    chk("t6_fault_range", bus.fetch_fault, 1'b1);
    chk("t6_range_valid", bus.inst_valid, 1'b0);
    bus.fetch_addr = 32'hFC; #1;
    chk("t6_nofault", bus.fetch_fault, 1'b0);
    chk("t6_nofault_inst", bus.inst, 32'hB1);
`else
    bus.fetch_addr = 32'h102; #1;
    chk("t6_fault_tied", bus.fetch_fault, 1'b0);
    chk("t6_alias_inst", bus.inst, 32'hB2);
    chk("t6_alias_valid", bus.inst_valid, 1'b1);
`endif

    // 7: oversize count clamps to DEPTH, base 40 wraps over whole array
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back(32'h1000 + 32'(i));
    do_load(6'd40, 7'd127, 64, "t7");
    fetch(32'hA0, 32'h1000, "t7_f40");
    fetch(32'h9C, 32'h103F, "t7_f39");
    fetch(32'h00, 32'h1018, "t7_f0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
